// File: rtl/packet_serializer.sv
// packet_serializer: parallel-to-serial converter with a one-word holding buffer.
// A shift register drives the serial output. A holding register lets the next word
// wait, so that back-to-back words come out as one gapless bit stream.
module packet_serializer #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_packet,
  output logic             o_bit_strobe,
  output logic             o_last,
  output logic             o_busy
);

  localparam int unsigned PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic             hold_full, hold_full_nxt;

  logic take;
  logic bit_end;
  logic word_end;

  // A word transfers whenever the holding slot is free
  assign take     = i_valid & ~hold_full;
  assign bit_end  = (state == SHIFT) && (presc == PRESC_MAX);
  assign word_end = bit_end && (idx == IDX_MAX);

  // State and datapath registers; reset clears everything, discarding in-flight words
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      presc     <= '0;
      idx       <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      idx       <= idx_nxt;
      shreg     <= shreg_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  // Next-state and datapath update: load, shift, refill from the holding slot
  always_comb begin
    state_nxt     = state;
    presc_nxt     = presc;
    idx_nxt       = idx;
    shreg_nxt     = shreg;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;

    case (state)
      IDLE: begin
        if (take) begin
          state_nxt = SHIFT;
          shreg_nxt = i_data;
          presc_nxt = '0;
          idx_nxt   = '0;
        end
      end

      SHIFT: begin
        if (word_end) begin
          // Final bit period ends: refill from hold, else from input, else go idle.
          // A full hold blocks take, so both sources never compete.
          presc_nxt = '0;
          idx_nxt   = '0;
          if (hold_full) begin
            shreg_nxt     = hold;
            hold_full_nxt = 1'b0;
          end else if (take) begin
            shreg_nxt = i_data;
          end else begin
            state_nxt = IDLE;
            shreg_nxt = '0;
          end
        end else begin
          if (take) begin
            hold_nxt      = i_data;
            hold_full_nxt = 1'b1;
          end
          if (bit_end) begin
            presc_nxt = '0;
            idx_nxt   = idx + IW'(1);
            shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
          end else begin
            presc_nxt = presc + PW'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state, so async reset shows at once
  assign o_ready      = ~hold_full;
  assign o_busy       = (state == SHIFT) | hold_full;
  assign o_packet     = (state == SHIFT) & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign o_bit_strobe = (state == SHIFT) && (presc == '0);
  assign o_last       = (state == SHIFT) && (idx == IDX_MAX);

endmodule
